// File: rtl/image_write_scheduler_if.sv
// Write-request, fill-control and image-RAM write port bundle for the
// image write scheduler. The scheduler side uses the slave modport; the
// requester / RAM-model side uses the master modport.
interface image_write_scheduler_if #(
  parameter int ADDRESS_WIDTH = 15,
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 8
);
  // pixel write request handshake
  logic                         req_valid;
  logic [ADDRESS_WIDTH-1:0]     req_addr;
  logic [DATA_WIDTH-1:0]        req_data;
  logic                         req_ready;
  // whole-frame fill control
  logic                         fill_start;
  logic [DATA_WIDTH-1:0]        fill_color;
  // scanout owns the RAM port while active is high
  logic                         active;
  // image RAM write port
  logic                         ram_wEn;
  logic [ADDRESS_WIDTH-1:0]     ram_addr;
  logic [DATA_WIDTH-1:0]        ram_data;
  // status
  logic                         busy;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;

  modport master (
    output req_valid, req_addr, req_data, fill_start, fill_color, active,
    input  req_ready, ram_wEn, ram_addr, ram_data, busy, fifo_count
  );

  modport slave (
    input  req_valid, req_addr, req_data, fill_start, fill_color, active,
    output req_ready, ram_wEn, ram_addr, ram_data, busy, fifo_count
  );
endinterface

// File: rtl/image_write_scheduler.sv
// Image write scheduler: queues pixel writes in a small FIFO and issues them
// to the image RAM only while scanout is outside the visible region. A
// whole-frame fill can be requested; it waits for the queue to drain, then
// writes the latched colour to addresses 0..FILL_LAST, pausing whenever
// scanout owns the RAM port.
module image_write_scheduler #(
  parameter int ADDRESS_WIDTH = 15,
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 8,     // power of two, >= 2
  parameter int FILL_LAST     = 16383
) (
  input  logic                   clock,
  input  logic                   reset,
  image_write_scheduler_if.slave bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDRESS_WIDTH-1:0] LAST  = ADDRESS_WIDTH'(FILL_LAST);
  localparam logic [CW-1:0]            DEPTH = CW'(FIFO_DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
  } wr_req_t;

  // control state
  state_t                   r_state,        w_state_nxt;
  logic                     r_fill_pending, w_fill_pending_nxt;
  logic [ADDRESS_WIDTH-1:0] r_fill_cnt,     w_fill_cnt_nxt;
  logic [DATA_WIDTH-1:0]    r_fill_color,   w_fill_color_nxt;

  // write queue
  wr_req_t                  r_mem [FIFO_DEPTH];
  logic [PW-1:0]            r_wr_ptr;
  logic [PW-1:0]            r_rd_ptr;
  logic [CW-1:0]            r_count;

  // registered RAM write port
  logic                     r_ram_wEn;
  logic [ADDRESS_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0]    r_ram_data;

  logic                     w_ready;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_fill_wr;
  wr_req_t                  w_head;

  // New requests are refused once a fill has been asked for, so the fill
  // sees a queue that only ever shrinks.
  assign w_ready = (r_count < DEPTH) && !r_fill_pending && (r_state != S_FILL);
  assign w_push  = bus.req_valid && w_ready;
  assign w_head  = r_mem[r_rd_ptr];

  // Next-state and write-issue decisions for the IDLE/FILL controller
  always_comb begin
    w_state_nxt        = r_state;
    w_fill_pending_nxt = r_fill_pending;
    w_fill_cnt_nxt     = r_fill_cnt;
    w_fill_color_nxt   = r_fill_color;
    w_pop              = 1'b0;
    w_fill_wr          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          // queued writes always go before a pending fill
          w_pop = !bus.active;
        end else if (r_fill_pending) begin
          w_state_nxt        = S_FILL;
          w_fill_pending_nxt = 1'b0;
          w_fill_cnt_nxt     = '0;
        end
        if (bus.fill_start && !r_fill_pending) begin
          w_fill_pending_nxt = 1'b1;
          w_fill_color_nxt   = bus.fill_color;
        end
      end
      S_FILL: begin
        if (!bus.active) begin
          w_fill_wr = 1'b1;
          // counter parks on the last address instead of wrapping
          if (r_fill_cnt == LAST) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_fill_cnt_nxt = r_fill_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Controller state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_fill_pending <= 1'b0;
      r_fill_cnt     <= '0;
      r_fill_color   <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_fill_pending <= w_fill_pending_nxt;
      r_fill_cnt     <= w_fill_cnt_nxt;
      r_fill_color   <= w_fill_color_nxt;
    end
  end

  // Queue storage; emptiness is defined by r_count so no reset is needed
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{addr: bus.req_addr, data: bus.req_data};
    end
  end

  // Queue pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // RAM write port: one-cycle strobe, address/data hold between writes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ram_wEn  <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
    end else begin
      r_ram_wEn <= w_pop || w_fill_wr;
      if (w_pop) begin
        r_ram_addr <= w_head.addr;
        r_ram_data <= w_head.data;
      end else if (w_fill_wr) begin
        r_ram_addr <= r_fill_cnt;
        r_ram_data <= r_fill_color;
      end
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.ram_wEn    = r_ram_wEn;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_data   = r_ram_data;
  assign bus.busy       = r_fill_pending || (r_state == S_FILL);
  assign bus.fifo_count = r_count;

endmodule

// File: tb/tb_image_write_scheduler.sv
// Bench for image_write_scheduler: directed scenarios plus a randomized
// push/scanout phase. Every RAM write is matched against a queue of expected
// {addr,data} built from the requests and fills the bench issues.
module tb_image_write_scheduler;
  localparam int AW = 15;
  localparam int DW = 8;
  localparam int FD = 8;
  localparam int FL = 16383;

  logic clock;
  logic reset;

  image_write_scheduler_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus ();

  image_write_scheduler #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .FILL_LAST(FL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   n_writes = 0;
  logic mon_en   = 1'b0;
  logic act_q    = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_fill(input logic [DW-1:0] c);
    for (int a = 0; a <= FL; a++) expect_wr(AW'(a), c);
  endtask

  // scanout level seen by the edge that decides the next write
  always @(posedge clock) act_q <= bus.active;

  // Scoreboard: each strobed write must be the next expected one
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (act_q) check("wen_during_active", bus.ram_wEn, 0);
      if (bus.ram_wEn === 1'b1) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          check("no_write_expected", bus.ram_wEn, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_addr", bus.ram_addr, e.addr);
          check("write_data", bus.ram_data, e.data);
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m_count;
    logic m_wen, push, pop;
    int n0;

    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    bus.fill_start = 1'b0;
    bus.fill_color = '0;
    bus.active     = 1'b0;
    reset          = 1'b1;
    repeat (3) @(negedge clock);

    // reset state
    check("rst_wen",   bus.ram_wEn, 0);
    check("rst_addr",  bus.ram_addr, 0);
    check("rst_data",  bus.ram_data, 0);
    check("rst_busy",  bus.busy, 0);
    check("rst_count", bus.fifo_count, 0);
    check("rst_ready", bus.req_ready, 1);
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();

    // single write latency
    bus.req_valid = 1'b1;
    bus.req_addr  = 15'h0123;
    bus.req_data  = 8'h5A;
    expect_wr(15'h0123, 8'h5A);
    tick();
    bus.req_valid = 1'b0;
    check("s1_count_queued", bus.fifo_count, 1);
    check("s1_wen_not_yet",  bus.ram_wEn, 0);
    tick();
    check("s1_wen",   bus.ram_wEn, 1);
    check("s1_addr",  bus.ram_addr, 15'h0123);
    check("s1_data",  bus.ram_data, 8'h5A);
    check("s1_count_empty", bus.fifo_count, 0);
    tick();
    check("s1_wen_one_cycle", bus.ram_wEn, 0);
    check("s1_addr_hold", bus.ram_addr, 15'h0123);

    // fill the queue during scanout, then burst out
    bus.active = 1'b1;
    for (int i = 0; i < FD; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = AW'($urandom);
      bus.req_data  = DW'($urandom);
      expect_wr(bus.req_addr, bus.req_data);
      tick();
    end
    bus.req_addr = 15'h7FFF;
    bus.req_data = 8'hEE;
    check("s2_count_full", bus.fifo_count, FD);
    check("s2_ready_full", bus.req_ready, 0);
    tick();
    bus.req_valid = 1'b0;
    check("s2_count_no_overflow", bus.fifo_count, FD);
    check("s2_wen_held", bus.ram_wEn, 0);
    bus.active = 1'b0;
    for (int i = 0; i < FD; i++) begin
      tick();
      check("s2_burst_wen", bus.ram_wEn, 1);
    end
    check("s2_count_drained", bus.fifo_count, 0);
    check("s2_ready_back", bus.req_ready, 1);
    tick();
    check("s2_burst_end", bus.ram_wEn, 0);

    // randomized pushes against random scanout activity
    m_count = 0;
    m_wen   = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      check("rnd_count", bus.fifo_count, m_count);
      check("rnd_ready", bus.req_ready, m_count < FD);
      check("rnd_wen",   bus.ram_wEn, m_wen);
      bus.active    = ($urandom_range(0, 99) < ((cyc / 250) % 2 == 0 ? 30 : 70));
      bus.req_valid = ($urandom_range(0, 99) < 60);
      bus.req_addr  = AW'($urandom);
      bus.req_data  = DW'($urandom);
      push = bus.req_valid && (m_count < FD);
      pop  = (m_count > 0) && !bus.active;
      if (push) expect_wr(bus.req_addr, bus.req_data);
      m_count = m_count + int'(push) - int'(pop);
      m_wen   = pop;
      tick();
    end
    bus.req_valid = 1'b0;
    bus.active    = 1'b0;
    repeat (FD + 4) tick();
    check("rnd_all_written", exp_q.size(), 0);

    // queued writes ahead of a fill
    bus.active = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = AW'(16'h4000 + i * 16'h0111);
      bus.req_data  = DW'(8'hA0 + i);
      expect_wr(bus.req_addr, bus.req_data);
      tick();
    end
    bus.req_valid  = 1'b0;
    bus.fill_start = 1'b1;
    bus.fill_color = 8'h07;
    tick();
    bus.fill_start = 1'b0;
    bus.fill_color = 8'h55;
    check("s3_busy",  bus.busy, 1);
    check("s3_ready", bus.req_ready, 0);
    check("s3_count", bus.fifo_count, 3);
    expect_fill(8'h07);
    n0 = n_writes;
    bus.active = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      tick();
      if (bus.busy === 1'b0) break;
    end
    check("s3_busy_fell", bus.busy, 0);
    check("s3_last_wen",  bus.ram_wEn, 1);
    check("s3_last_addr", bus.ram_addr, FL);
    tick();
    check("s3_done_wen", bus.ram_wEn, 0);
    check("s3_total_writes", n_writes - n0, 3 + FL + 1);
    check("s3_all_written", exp_q.size(), 0);

    // fill with scanout interruption and an ignored second fill_start
    bus.fill_start = 1'b1;
    bus.fill_color = 8'h2C;
    expect_fill(8'h2C);
    n0 = n_writes;
    tick();
    bus.fill_start = 1'b0;
    check("s4_busy", bus.busy, 1);
    repeat (3000) tick();
    check("s4_ready_in_fill", bus.req_ready, 0);
    bus.fill_start = 1'b1;
    bus.fill_color = 8'h33;
    tick();
    bus.fill_start = 1'b0;
    bus.active     = 1'b1;
    repeat (10) tick();
    bus.active = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      tick();
      if (bus.busy === 1'b0) break;
    end
    check("s4_busy_fell", bus.busy, 0);
    repeat (3) tick();
    check("s4_total_fill_writes", n_writes - n0, FL + 1);
    check("s4_all_written", exp_q.size(), 0);
    check("s4_no_refill", bus.busy, 0);

    // reset in the middle of a fill
    bus.fill_start = 1'b1;
    bus.fill_color = 8'h11;
    expect_fill(8'h11);
    tick();
    bus.fill_start = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      tick();
      if (bus.ram_wEn === 1'b1 && bus.ram_addr === 15'h2000) break;
    end
    check("s5_reached_2000", bus.ram_addr, 15'h2000);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("s5_rst_wen",   bus.ram_wEn, 0);
    check("s5_rst_busy",  bus.busy, 0);
    check("s5_rst_count", bus.fifo_count, 0);
    check("s5_rst_addr",  bus.ram_addr, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (20) tick();
    check("s5_idle_busy",  bus.busy, 0);
    check("s5_idle_ready", bus.req_ready, 1);
    check("s5_idle_wen",   bus.ram_wEn, 0);

    // fresh request after the abort is written normally
    bus.req_valid = 1'b1;
    bus.req_addr  = 15'h1ABC;
    bus.req_data  = 8'hC3;
    expect_wr(15'h1ABC, 8'hC3);
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("s5_post_wen",  bus.ram_wEn, 1);
    check("s5_post_addr", bus.ram_addr, 15'h1ABC);
    tick();
    check("s5_post_all_written", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/image_write_scheduler.md
IMAGE_WRITE_SCHEDULER -- requirements
Module: image_write_scheduler

Interface
REQ-001 The block SHALL use one clock and one reset: clock, rising-edge; reset asynchronous, active-high.
REQ-002 The block SHALL have these parameters:
- ADDRESS_WIDTH, 15, image RAM address width.
- DATA_WIDTH, 8, palette-index width.
- FIFO_DEPTH, 8, write-queue entries (power of two).
- FILL_LAST, 16383, last address written by a fill.
REQ-003 The block SHALL have these ports:
- clock  in  1  pixel clock, shared with the scanout counter.
- reset  in  1  asynchronous active-high reset.
- req_valid  in  1  write request present.
- req_addr  in  ADDRESS_WIDTH  target pixel address.
- req_data  in  DATA_WIDTH  palette index.
- req_ready  out  1  request accepted on this edge when high with req_valid.
- fill_start  in  1  single-cycle pulse requesting whole-frame fill.
- fill_color  in  DATA_WIDTH  fill palette index, sampled with fill_start.
- active  in  1  scanout in visible region; RAM port owned by scanout.
- ram_wEn  out  1  image RAM write enable.
- ram_addr  out  ADDRESS_WIDTH  image RAM write address.
- ram_data  out  DATA_WIDTH  image RAM write data.
- busy  out  1  fill pending or in progress.
- fifo_count  out  log2(FIFO_DEPTH)+1  queued entries.

Function
REQ-004 The block SHALL have states IDLE, FILL; a fill_pending flag; and a FIFO of {addr,data}.
REQ-005 req_ready SHALL equal (fifo_count < FIFO_DEPTH) and not fill_pending and state != FILL.
REQ-006 A request SHALL be pushed on a rising edge where req_valid and req_ready are both high; simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-007 In IDLE, when the FIFO is non-empty and active is low, the head SHALL be popped, and ram_wEn=1, ram_addr, ram_data SHALL be registered on that edge: a request accepted at edge E, with active low, appears on the RAM outputs after edge E+1.
REQ-008 When active is high, no pop and no fill write SHALL occur; ram_wEn SHALL be 0 on the next cycle; ram_addr/ram_data hold their last values.
REQ-009 ram_wEn SHALL be registered and SHALL be high for exactly one cycle per write; writes SHALL issue in FIFO order, at most one per cycle.
REQ-010 fill_start in IDLE with fill_pending low SHALL latch fill_color and set fill_pending; fill_start while fill_pending or FILL SHALL be ignored.
REQ-011 With fill_pending set, the FIFO SHALL drain first; when empty, the state SHALL go IDLE->FILL, clear fill_pending, and set the fill counter to 0.
REQ-012 In FILL, each cycle with active low SHALL write fill_color to the fill counter address, then increment the counter; after writing FILL_LAST, the state SHALL return to IDLE on the same edge.
REQ-013 busy SHALL be high while fill_pending is set or the state is FILL.
REQ-014 Fill counter arithmetic SHALL be ADDRESS_WIDTH bits with no wrap beyond FILL_LAST.
REQ-015 The FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-016 On reset assertion, asynchronously: state=IDLE, fill_pending=0, FIFO emptied (fifo_count=0), fill counter=0, ram_wEn=0, ram_addr=0, ram_data=0, busy=0, latched fill color=0.
REQ-017 Reset during FILL or with queued entries SHALL abort all pending work; no write SHALL issue on the first edge after deassertion.

Verification
REQ-018 The bench SHALL cover these scenarios:
- active=0; push addr 0x0123, data 0x5A -> ram_wEn=1, ram_addr=0x0123, ram_data=0x5A exactly one cycle, after edge E+1; fifo_count returns to 0.
- active=1; push 8 requests -> fifo_count=8, req_ready=0, ram_wEn stays 0; drop active -> 8 consecutive writes in push order, then req_ready=1.
- 3 queued writes, active=1, fill_start with fill_color=0x07 -> busy=1, req_ready=0; active=0 -> 3 queued writes first, then fill 0..16383 with 0x07; busy falls after addr 16383.
- Fill running; toggle active 1 for 10 cycles mid-fill -> no addresses skipped or duplicated; total fill writes = 16384.
- Fill at counter 0x2000; assert reset -> ram_wEn=0, busy=0, fifo_count=0 immediately; after release, no writes until new requests.
- fill_start pulsed again during FILL with 0x33 -> ignored; all fill writes carry the original color.
